// File: rtl/parking_pkg.sv
// Shared state encoding and sensor patterns for the parking gate decoder.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EN1      = 3'd1,
        EN2      = 3'd2,
        EN3      = 3'd3,
        EX1      = 3'd4,
        EX2      = 3'd5,
        EX3      = 3'd6,
        WAIT_CLR = 3'd7
    } state_t;

    // Sensor pattern {a, b}: a = outer beam, b = inner beam.
    localparam logic [1:0] CLEAR = 2'b00;
    localparam logic [1:0] OUTER = 2'b10;
    localparam logic [1:0] BOTH  = 2'b11;
    localparam logic [1:0] INNER = 2'b01;

    // True in the mid-sequence states where the stall timeout applies.
    function automatic logic is_active(input state_t s);
        return (s != IDLE) && (s != WAIT_CLR);
    endfunction

endpackage

// File: rtl/sensor_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous sensor line.
module sensor_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw level through the chain; cleared on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/parking_sensor_decoder.sv
// Turns the outer/inner gate beams into entry/exit pulses, rejecting
// aborted, illegal and stalled sequences.
module parking_sensor_decoder
    import parking_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic inc,
    output logic dec,
    output logic busy,
    output logic err
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             a_sync;
    logic             b_sync;
    logic [1:0]       ab;
    logic [1:0]       prev_ab;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             inc_next;
    logic             dec_next;
    logic             err_next;
    logic             stalled;

    sensor_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .reset (reset),
        .d     (a),
        .q     (a_sync)
    );

    sensor_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .reset (reset),
        .d     (b),
        .q     (b_sync)
    );

    assign ab = {a_sync, b_sync};

    // Next-state, pulse and stall-counter decode.
    always_comb begin
        state_next = state;
        inc_next   = 1'b0;
        dec_next   = 1'b0;
        err_next   = 1'b0;
        cnt_next   = cnt;
        // A stall can only be declared while the pattern is unchanged, so a
        // legal move arriving on the last allowed cycle still wins.
        stalled    = is_active(state) && (ab == prev_ab) && (cnt == CNT_LAST);

        if (stalled) begin
            err_next   = 1'b1;
            state_next = WAIT_CLR;
        end else begin
            case (state)
                IDLE: begin
                    if (ab == OUTER)      state_next = EN1;
                    else if (ab == INNER) state_next = EX1;
                    else if (ab == BOTH) begin
                        err_next   = 1'b1;
                        state_next = WAIT_CLR;
                    end
                end
                EN1: begin
                    if (ab == BOTH)       state_next = EN2;
                    else if (ab == CLEAR) state_next = IDLE;
                    else if (ab == INNER) begin
                        err_next   = 1'b1;
                        state_next = WAIT_CLR;
                    end
                end
                EN2: begin
                    if (ab == INNER)      state_next = EN3;
                    else if (ab == OUTER) state_next = EN1;
                    else if (ab == CLEAR) begin
                        err_next   = 1'b1;
                        state_next = WAIT_CLR;
                    end
                end
                EN3: begin
                    if (ab == CLEAR) begin
                        inc_next   = 1'b1;
                        state_next = IDLE;
                    end else if (ab == BOTH) begin
                        state_next = EN2;
                    end else if (ab == OUTER) begin
                        err_next   = 1'b1;
                        state_next = WAIT_CLR;
                    end
                end
                EX1: begin
                    if (ab == BOTH)       state_next = EX2;
                    else if (ab == CLEAR) state_next = IDLE;
                    else if (ab == OUTER) begin
                        err_next   = 1'b1;
                        state_next = WAIT_CLR;
                    end
                end
                EX2: begin
                    if (ab == OUTER)      state_next = EX3;
                    else if (ab == INNER) state_next = EX1;
                    else if (ab == CLEAR) begin
                        err_next   = 1'b1;
                        state_next = WAIT_CLR;
                    end
                end
                EX3: begin
                    if (ab == CLEAR) begin
                        dec_next   = 1'b1;
                        state_next = IDLE;
                    end else if (ab == BOTH) begin
                        state_next = EX2;
                    end else if (ab == INNER) begin
                        err_next   = 1'b1;
                        state_next = WAIT_CLR;
                    end
                end
                WAIT_CLR: begin
                    if (ab == CLEAR) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end

        if (stalled || !is_active(state) || (ab != prev_ab)) begin
            cnt_next = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // State, previous pattern, stall counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            prev_ab <= CLEAR;
            cnt     <= '0;
            inc     <= 1'b0;
            dec     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            prev_ab <= ab;
            cnt     <= cnt_next;
            inc     <= inc_next;
            dec     <= dec_next;
            err     <= err_next;
            busy    <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_parking_sensor_decoder.sv
// Directed, table-driven bench for parking_sensor_decoder.
module tb_parking_sensor_decoder;

    localparam int unsigned SYNC_STAGES    = 2;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic clk = 1'b0;
    logic reset;
    logic a;
    logic b;
    logic inc;
    logic dec;
    logic busy;
    logic err;

    int checks  = 0;
    int errors  = 0;
    int overlap = 0;

    // One segment: drive raw {a,b} for hold cycles, then compare what was seen.
    // exp_first is the 1-based sample of the first pulse of any kind (0 = none).
    typedef struct {
        logic [1:0] ab;
        int         hold;
        int         exp_inc;
        int         exp_dec;
        int         exp_err;
        logic       exp_busy;
        int         exp_first;
    } vec_t;

    vec_t vecs[$];

    parking_sensor_decoder #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .inc   (inc),
        .dec   (dec),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] ab, input int hold, input int ei,
                                input int ed, input int ee, input logic eb, input int ef);
        vec_t v;
        v.ab        = ab;
        v.hold      = hold;
        v.exp_inc   = ei;
        v.exp_dec   = ed;
        v.exp_err   = ee;
        v.exp_busy  = eb;
        v.exp_first = ef;
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Called at a negedge; drives, samples each following negedge, then compares.
    task automatic apply_vec(input vec_t v, input string tag);
        int n_inc = 0;
        int n_dec = 0;
        int n_err = 0;
        int first = 0;
        a = v.ab[1];
        b = v.ab[0];
        for (int c = 1; c <= v.hold; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (inc) n_inc++;
            if (dec) n_dec++;
            if (err) n_err++;
            if ((inc || dec || err) && first == 0) first = c;
            if ((inc && dec) || (inc && err) || (dec && err)) overlap++;
        end
        check({tag, "_inc"},  n_inc, v.exp_inc);
        check({tag, "_dec"},  n_dec, v.exp_dec);
        check({tag, "_err"},  n_err, v.exp_err);
        check({tag, "_busy"}, int'(busy), int'(v.exp_busy));
        if (v.exp_first != 0) check({tag, "_latency"}, first, v.exp_first);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] seq [8];
        int n_inc;
        int n_rise;
        int n_other;
        logic prev_inc;

        // 1: entry
        vecs.push_back(mk(2'b00, 5, 0, 0, 0, 1'b0, 0));
        vecs.push_back(mk(2'b10, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b11, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b01, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b00, 5, 1, 0, 0, 1'b0, 3));
        // 2: exit
        vecs.push_back(mk(2'b01, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b11, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b10, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b00, 5, 0, 1, 0, 1'b0, 3));
        // 3: aborted entry, then full entry
        vecs.push_back(mk(2'b10, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b11, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b10, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b00, 5, 0, 0, 0, 1'b0, 0));
        vecs.push_back(mk(2'b10, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b11, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b01, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b00, 5, 1, 0, 0, 1'b0, 3));
        // 4: illegal jump, then valid exit
        vecs.push_back(mk(2'b11, 6, 0, 0, 1, 1'b1, 3));
        vecs.push_back(mk(2'b00, 5, 0, 0, 0, 1'b0, 0));
        vecs.push_back(mk(2'b01, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b11, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b10, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b00, 5, 0, 1, 0, 1'b0, 3));
        // 5: stall in EN1 (EN1 entered at posedge 3, err 16 cycles later)
        vecs.push_back(mk(2'b10, 30, 0, 0, 1, 1'b1, 19));
        vecs.push_back(mk(2'b11, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b01, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b00, 5, 0, 0, 0, 1'b0, 0));
        // 6 setup: walk to EN3
        vecs.push_back(mk(2'b10, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b11, 5, 0, 0, 0, 1'b1, 0));
        vecs.push_back(mk(2'b01, 5, 0, 0, 0, 1'b1, 0));

        reset = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_inc",  int'(inc),  0);
        check("rst_dec",  int'(dec),  0);
        check("rst_err",  int'(err),  0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while in EN3 drops the car.
        reset = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("en3rst_inc",  int'(inc),  0);
        check("en3rst_dec",  int'(dec),  0);
        check("en3rst_err",  int'(err),  0);
        check("en3rst_busy", int'(busy), 0);
        reset = 1'b1;
        apply_vec(mk(2'b00, 5, 0, 0, 0, 1'b0, 0), "after_rst");

        // Two entries back to back, one cycle per pattern, no gap.
        seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
        seq[4] = 2'b10; seq[5] = 2'b11; seq[6] = 2'b01; seq[7] = 2'b00;
        n_inc    = 0;
        n_rise   = 0;
        n_other  = 0;
        prev_inc = 1'b0;
        for (int i = 0; i < 14; i++) begin
            a = (i < 8) ? seq[i][1] : 1'b0;
            b = (i < 8) ? seq[i][0] : 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (inc) n_inc++;
            if (inc && !prev_inc) n_rise++;
            if (dec || err) n_other++;
            prev_inc = inc;
        end
        check("b2b_inc_cycles", n_inc,   2);
        check("b2b_inc_pulses", n_rise,  2);
        check("b2b_dec_err",    n_other, 0);
        check("b2b_busy",       int'(busy), 0);

        check("pulse_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_sensor_decoder.md
Name: parking_sensor_decoder

Overview:
Converts two raw photo-sensor lines at a parking-lot gate into single-cycle increment/decrement pulses for the lot's saturating occupancy counter. Sensor a is the outer beam and b is the inner beam. A car entering breaks a, then a+b, then b, then clears; an exit is the reverse sequence. The block synchronizes the asynchronous sensors, tracks the sequence with an FSM, and rejects aborted, illegal or stalled sequences.

Parameters:
SYNC_STAGES, 2, number of flops in each sensor synchronizer chain (minimum 2).
TIMEOUT_CYCLES, 1024, cycles a mid-sequence sensor pattern may stay unchanged before the sequence is abandoned (minimum 4).

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-low reset (reset==0 resets on the next posedge).
a  input  1  outer sensor, asynchronous, 1 = beam blocked.
b  input  1  inner sensor, asynchronous, 1 = beam blocked.
inc  output  1  one-cycle pulse: one car fully entered.
dec  output  1  one-cycle pulse: one car fully exited.
busy  output  1  FSM is not in IDLE.
err  output  1  one-cycle pulse: illegal transition or timeout.

Behaviour:
- Reset (reset==0 at posedge):
  - sync flops = 0, state = IDLE, timeout counter = 0.
  - inc = dec = err = 0; busy = 0.
  - Reset mid-sequence drops the sequence with no pulse.
- Sampled pattern: ab = {a_sync, b_sync}. All transitions use ab.
- States and transitions (any unlisted ab means stay):
  - IDLE: 10->EN1; 01->EX1; 11->err, WAIT_CLR.
  - EN1: 11->EN2; 00->IDLE (backed out, no pulse); 01->err, WAIT_CLR.
  - EN2: 01->EN3; 10->EN1; 00->err, WAIT_CLR.
  - EN3: 00->IDLE with inc; 11->EN2; 10->err, WAIT_CLR.
  - EX1: 11->EX2; 00->IDLE (no pulse); 10->err, WAIT_CLR.
  - EX2: 10->EX3; 01->EX1; 00->err, WAIT_CLR.
  - EX3: 00->IDLE with dec; 11->EX2; 01->err, WAIT_CLR.
  - WAIT_CLR: stay until ab==00, then ->IDLE. No pulses in this state.
- Output timing:
  - inc, dec and err are registered, high for exactly one cycle, and never high together.
  - inc and dec are mutually exclusive by construction.
  - Latency: raw {a,b} reaching 00 to the inc/dec rising edge = SYNC_STAGES+1 posedges.
- busy is registered and equals (next_state != IDLE), so it is aligned with the state register.
- Timeout:
  - Counter clears whenever ab differs from the previous ab, and in IDLE and WAIT_CLR.
  - Otherwise it increments once per cycle; width $clog2(TIMEOUT_CYCLES+1), no wrap.
  - When the counter reaches TIMEOUT_CYCLES-1 in EN1..EX3: err pulse, ->WAIT_CLR, counter clears.
- Back-to-back cars: returning to IDLE and then seeing 10 on the following cycle starts a new sequence. No dead cycles are required.
- After reset release with sensors already blocked, the normal rules apply. For example, 11 from IDLE gives an err pulse and WAIT_CLR.

Decomposition:
- Package parking_pkg holds:
  - state_t enum (IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLR).
  - Localparam sensor patterns CLEAR=2'b00, OUTER=2'b10, BOTH=2'b11, INNER=2'b01.
- One sub-module, sensor_sync: a parameterized SYNC_STAGES-deep single-bit synchronizer with synchronous active-low reset to 0. It is instantiated once each for a and b.

Test Plan:
1. Entry: raw ab = 00,10,11,01,00, each held 5 cycles. Required: exactly one inc pulse, rising 3 posedges after 00 is applied; dec=err=0; busy low after the pulse.
2. Exit: ab = 00,01,11,10,00, each held 5 cycles. Required: exactly one dec pulse at the same latency; inc=0.
3. Aborted entry: ab = 10,11,10,00. Required: no inc/dec/err; busy returns to 0. Follow with a full entry; required: one inc.
4. Illegal jump: ab 00->11, held 6 cycles, then 00. Required: one err pulse; busy stays 1 until 00 is synchronized; no inc/dec. A following valid exit must give one dec.
5. Timeout with TIMEOUT_CYCLES=16: hold ab=10 for 30 cycles. Required: err pulse 16 cycles after EN1 is entered; the FSM sits in WAIT_CLR. A later 11,01,00 must give no inc; IDLE only after 00.
6. Reset during EN3: drive reset=0 for one cycle, then ab=00. Required: no inc; all outputs 0 the cycle after reset. Then two back-to-back full entries; required: two separate one-cycle inc pulses.
